// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution with link/target generation, mispredict flagging and statistics.
// Define BRANCH_PREDICT_EN to include the bimodal 2-bit history table; otherwise prediction is static not-taken.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int BHT_IDX_BITS = 6,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [2:0]        res_op,
  input  logic [XLEN-1:0]   res_pc,
  input  logic [XLEN-1:0]   res_a,
  input  logic [XLEN-1:0]   res_b,
  input  logic [XLEN-1:0]   res_imm,
  input  logic              res_pred_taken,
  output logic              out_valid,
  output logic              out_taken,
  output logic [XLEN-1:0]   out_target,
  output logic [XLEN-1:0]   out_link,
  output logic              out_mispredict,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  typedef enum logic [2:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLT  = 3'd2,
    OP_BGE  = 3'd3,
    OP_BLTU = 3'd4,
    OP_BGEU = 3'd5,
    OP_JAL  = 3'd6,
    OP_JALR = 3'd7
  } op_e;

  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  op_e             op;
  logic            eq, lt, ltu;
  logic            taken, mispredict;
  logic [XLEN-1:0] target, jalr_sum;

  // NOTE: every signal written in an always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    op         = op_e'(res_op);
    eq         = (res_a == res_b);
    lt         = ($signed(res_a) < $signed(res_b));
    ltu        = (res_a < res_b);
    jalr_sum   = res_a + res_imm;
    taken      = 1'b1;
    target     = res_pc + res_imm;
    mispredict = 1'b1;
    case (op)
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLT:  taken = lt;
      OP_BGE:  taken = !lt;
      OP_BLTU: taken = ltu;
      OP_BGEU: taken = !ltu;
      default: taken = 1'b1;
    endcase
    case (op)
      OP_JAL:  mispredict = !res_pred_taken;
      OP_JALR: begin
        mispredict = 1'b1;
        target     = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: mispredict = (taken != res_pred_taken);
    endcase
  end

  // Result registers hold their last value between strobes.
  logic            out_valid_q, out_valid_d;
  logic            out_taken_q, out_taken_d;
  logic            out_mispredict_q, out_mispredict_d;
  logic [XLEN-1:0] out_target_q, out_target_d;
  logic [XLEN-1:0] out_link_q, out_link_d;
  logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    out_valid_d        = res_valid;
    out_taken_d        = out_taken_q;
    out_mispredict_d   = out_mispredict_q;
    out_target_d       = out_target_q;
    out_link_d         = out_link_q;
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (res_valid) begin
      out_taken_d      = taken;
      out_mispredict_d = mispredict;
      out_target_d     = target;
      out_link_d       = res_pc + XLEN'(4);
    end
    if (stat_clr) begin
      stat_branches_d    = '0;
      stat_mispredicts_d = '0;
    end else if (res_valid) begin
      if (stat_branches_q != STAT_MAX)
        stat_branches_d = stat_branches_q + STAT_W'(1);
      if (mispredict && stat_mispredicts_q != STAT_MAX)
        stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q        <= 1'b0;
      out_taken_q        <= 1'b0;
      out_mispredict_q   <= 1'b0;
      out_target_q       <= '0;
      out_link_q         <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      out_valid_q        <= out_valid_d;
      out_taken_q        <= out_taken_d;
      out_mispredict_q   <= out_mispredict_d;
      out_target_q       <= out_target_d;
      out_link_q         <= out_link_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_taken        = out_taken_q;
  assign out_mispredict   = out_mispredict_q;
  assign out_target       = out_target_q;
  assign out_link         = out_link_q;
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

`ifdef BRANCH_PREDICT_EN
  localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;

  logic [1:0]              bht_q [BHT_ENTRIES];
  logic [1:0]              bht_d [BHT_ENTRIES];
  logic [BHT_IDX_BITS-1:0] res_idx, pred_idx;
  logic                    is_branch;
  logic                    unused_pred_pc;

  assign res_idx        = res_pc[BHT_IDX_BITS+1:2];
  assign pred_idx       = pred_pc[BHT_IDX_BITS+1:2];
  assign is_branch      = (res_op < 3'd6);
  assign unused_pred_pc = ^{pred_pc[XLEN-1:BHT_IDX_BITS+2], pred_pc[1:0]};

  always_comb begin
    bht_d = bht_q;
    if (res_valid && is_branch) begin
      if (taken && bht_q[res_idx] != 2'd3)
        bht_d[res_idx] = bht_q[res_idx] + 2'd1;
      else if (!taken && bht_q[res_idx] != 2'd0)
        bht_d[res_idx] = bht_q[res_idx] - 2'd1;
    end
  end

  // NOTE: the table is built from resettable flops rather than RAM because every counter must wake up weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

  // Reads the pre-edge table, so a same-cycle update to this index shows next cycle.
  assign pred_taken = bht_q[pred_idx][1];
`else
  logic unused_pred_pc;
  assign unused_pred_pc = ^pred_pc;
  assign pred_taken     = 1'b0;
`endif

endmodule
